// File: rtl/sr512_pkg.sv
// Shared constants, types and pure helpers for the SR-512 recovery datapath.
package sr512_pkg;

  localparam int SR_W    = 512;
  localparam int DELTA_W = 9;
  localparam int TAP1    = 157;
  localparam int TAP2    = 311;

  typedef logic [DELTA_W-1:0] delta_t;

  typedef struct packed {
    delta_t t0;
    delta_t t1;
    delta_t t2;
  } taps_t;

  // Rotate right through a doubled word so delta=0 is a clean identity.
  function automatic logic [SR_W-1:0] ror512(input logic [SR_W-1:0] word, input delta_t delta);
    logic [2*SR_W-1:0] dbl;
    dbl = {word, word} >> delta;
    return dbl[SR_W-1:0];
  endfunction

  function automatic delta_t mv9(input delta_t a, input delta_t b, input delta_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic taps_t delta_taps(input logic [SR_W-1:0] word);
    taps_t t;
    t.t0 = word[0 +: DELTA_W];
    t.t1 = word[TAP1 +: DELTA_W];
    t.t2 = word[TAP2 +: DELTA_W];
    return t;
  endfunction

endpackage

// File: rtl/sr512_rr_arb.sv
// Combinational round-robin arbiter; the rotating pointer is owned by the parent.
module sr512_rr_arb #(
  parameter  int N_LANES = 4,
  localparam int LANE_W  = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic               en,
  input  logic [LANE_W-1:0]  ptr,
  output logic [N_LANES-1:0] grant,
  output logic [LANE_W-1:0]  grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = (int'(ptr) + i) % N_LANES;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = LANE_W'(idx);
      end
    end
    // The index is still reported when blocked; only the one-hot grant is gated.
    if (found && en) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/sr512_lane_sched.sv
// Interleaves N measurement lanes onto one SR-512 recovery datapath with per-lane
// delta contexts and a single registered valid/ready output stage.
module sr512_lane_sched
  import sr512_pkg::*;
#(
  parameter  int               N_LANES   = 4,
  parameter  logic [SR_W-1:0]  KA_ANCHOR = '0,
  localparam int               LANE_W    = $clog2(N_LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_LANES-1:0]      req_valid,
  input  logic [N_LANES*SR_W-1:0] req_data,
  output logic [N_LANES-1:0]      req_ready,
  input  logic [N_LANES-1:0]      ctx_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SR_W-1:0]         out_data,
  output logic [LANE_W-1:0]       out_lane,
  output logic [DELTA_W-1:0]      out_delta
);

  logic                issue_en;
  logic                accept;
  logic [N_LANES-1:0]  grant;
  logic [LANE_W-1:0]   grant_idx;
  logic [LANE_W-1:0]   rr_ptr;
  delta_t              ctx [N_LANES];
  logic [SR_W-1:0]     lane_word [N_LANES];

  logic [SR_W-1:0]     word_p0;
  delta_t              delta_p0;
  taps_t               taps_p0;

  logic                vld_p1;
  logic [SR_W-1:0]     data_p1;
  logic [LANE_W-1:0]   lane_p1;
  delta_t              delta_p1;

  for (genvar i = 0; i < N_LANES; i++) begin : g_unpack
    assign lane_word[i] = req_data[i*SR_W +: SR_W];
  end

  assign issue_en = !vld_p1 | out_ready;

  sr512_rr_arb #(.N_LANES(N_LANES)) u_arb (
    .req       (req_valid),
    .en        (issue_en & ~rst),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Stage p0: select the granted lane and its context
  assign word_p0  = lane_word[grant_idx];
  assign delta_p0 = ctx[grant_idx];
  assign taps_p0  = delta_taps(word_p0);

  // Stage p1: registered output word and context update
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      lane_p1  <= '0;
      delta_p1 <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < N_LANES; i++) ctx[i] <= '0;
    end else begin
      if (accept) begin
        vld_p1   <= 1'b1;
        data_p1  <= ror512(word_p0, delta_p0) ^ KA_ANCHOR;
        lane_p1  <= grant_idx;
        delta_p1 <= delta_p0;
        rr_ptr   <= (grant_idx == LANE_W'(N_LANES-1)) ? '0 : grant_idx + 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      // A clear pulse beats the majority-vote update on the same lane.
      for (int i = 0; i < N_LANES; i++) begin
        if (ctx_clr[i])    ctx[i] <= '0;
        else if (grant[i]) ctx[i] <= mv9(taps_p0.t0, taps_p0.t1, taps_p0.t2);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_lane  = lane_p1;
  assign out_delta = delta_p1;

endmodule
